// File: rtl/tm1638_frame_writer.sv
// ---------------------------------------------------------------------------
// tm1638_frame_writer
//
// Purpose:
//   Writes one complete display frame to a TM1638 LED/key controller over its
//   three-wire serial bus. A frame is three commands, each framed by its own
//   stb-low window:
//     1. 0x40                       data command (write, auto-increment)
//     2. 0xC0, seg0, led0, ... segN-1, ledN-1   address + display RAM
//     3. 0x80 | display_on<<3 | brightness      display control
//   Bytes go out LSB first. Each bit has sclk low for CLK_DIV cycles, then
//   high for CLK_DIV cycles. dio changes only together with a falling sclk.
//
// Configuration macro:
//   TM1638_LED_EN  - when defined, adds the led_data port and sends
//                    {7'b0, led_data[k]} as the odd byte of digit k.
//                    When undefined, every odd byte is 0x00.
//
// Parameters:
//   NUM_DIGITS  digits written per frame (1..8)
//   CLK_DIV     clk_50M cycles per sclk half-period (2..255)
//
// Ports:
//   clk_50M     in   clock, all state on the rising edge
//   RST         in   asynchronous active-high reset
//   start       in   frame request, accepted only while busy is low
//   seg_data    in   segment byte per digit, digit k = [8k+7:8k]
//   brightness  in   pulse-width code 0..7
//   display_on  in   1 = display enabled in the control command
//   led_data    in   (TM1638_LED_EN only) one LED bit per digit
//   busy        out  high from the cycle after acceptance until done
//   done        out  one-cycle pulse at frame completion
//   stb         out  TM1638 strobe (active low)
//   sclk        out  TM1638 serial clock
//   dio         out  TM1638 serial data (write-only)
// ---------------------------------------------------------------------------
module tm1638_frame_writer #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 25
) (
  input  logic                    clk_50M,
  input  logic                    RST,
  input  logic                    start,
  input  logic [8*NUM_DIGITS-1:0] seg_data,
  input  logic [2:0]              brightness,
  input  logic                    display_on,
`ifdef TM1638_LED_EN
  input  logic [NUM_DIGITS-1:0]   led_data,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    stb,
  output logic                    sclk,
  output logic                    dio
);

  // The address/data window is the longest command: 0xC0 plus two bytes per
  // digit. One extra count of headroom lets the bit counter hold "next bit".
  localparam int DATA_BYTES = 2 * NUM_DIGITS + 1;
  localparam int DATA_BITS  = 8 * DATA_BYTES;
  localparam int BIT_W      = $clog2(DATA_BITS + 1);
  localparam int BYTE_W     = BIT_W - 3;
  localparam int DIV_W      = $clog2(2 * CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST      = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] CMD_LAST_BIT  = BIT_W'(7);
  localparam logic [BIT_W-1:0] DATA_LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, CMD_MODE, GAP1, ADDR_DATA, GAP2, CMD_CTRL, FINISH
  } state_t;

  // Within a command: LEAD is the stb-low/sclk-high setup time before the
  // first falling sclk, then each bit alternates LOW and HIGH.
  typedef enum logic [1:0] {PH_LEAD, PH_LOW, PH_HIGH} phase_t;

  state_t                  state_q, state_d;
  phase_t                  phase_q, phase_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [8*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [2:0]              bright_q, bright_d;
  logic                    on_q, on_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    stb_q, stb_d;
  logic                    sclk_q, sclk_d;
  logic                    dio_q, dio_d;

`ifdef TM1638_LED_EN
  logic [NUM_DIGITS-1:0]   led_q, led_d;
`else
  logic [NUM_DIGITS-1:0]   led_q;
  assign led_q = '0;
`endif

  // -------------------------------------------------------------------------
  // Transmit byte / bit selection. In PH_HIGH the bit being prepared is the
  // one after bit_q, because dio is loaded on the coming falling edge.
  // -------------------------------------------------------------------------
  logic [BIT_W-1:0]        sel_bit;
  logic [BYTE_W-1:0]       sel_byte;
  logic [BYTE_W-1:0]       data_idx;
  logic [8*NUM_DIGITS-1:0] seg_shift;
  logic [NUM_DIGITS-1:0]   led_shift;
  logic [7:0]              tx_byte;
  logic                    tx_bit;
  logic [BIT_W-1:0]        last_bit;

  always_comb begin
    sel_bit   = (phase_q == PH_HIGH) ? bit_q + BIT_W'(1) : bit_q;
    sel_byte  = sel_bit[BIT_W-1:3];
    // data_idx counts bytes after 0xC0: even = segments, odd = LED byte.
    data_idx  = sel_byte - BYTE_W'(1);
    seg_shift = seg_q >> {data_idx[BYTE_W-1:1], 3'b000};
    led_shift = led_q >> data_idx[BYTE_W-1:1];
    case (state_q)
      CMD_MODE:  tx_byte = 8'h40;
      ADDR_DATA: begin
        if (sel_byte == '0)      tx_byte = 8'hC0;
        else if (!data_idx[0])   tx_byte = seg_shift[7:0];
        else                     tx_byte = {7'b0, led_shift[0]};
      end
      CMD_CTRL:  tx_byte = {4'b1000, on_q, bright_q};
      default:   tx_byte = 8'hFF;
    endcase
    tx_bit   = tx_byte[sel_bit[2:0]];
    last_bit = (state_q == ADDR_DATA) ? DATA_LAST_BIT : CMD_LAST_BIT;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    div_d    = div_q;
    bit_d    = bit_q;
    seg_d    = seg_q;
    bright_d = bright_q;
    on_d     = on_q;
`ifdef TM1638_LED_EN
    led_d    = led_q;
`endif
    busy_d   = busy_q;
    done_d   = 1'b0;
    stb_d    = stb_q;
    sclk_d   = sclk_q;
    dio_d    = dio_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          seg_d    = seg_data;
          bright_d = brightness;
          on_d     = display_on;
`ifdef TM1638_LED_EN
          led_d    = led_data;
`endif
          busy_d   = 1'b1;
          stb_d    = 1'b0;
          sclk_d   = 1'b1;
          dio_d    = 1'b1;
          phase_d  = PH_LEAD;
          div_d    = '0;
          bit_d    = '0;
          state_d  = CMD_MODE;
        end
      end

      CMD_MODE, ADDR_DATA, CMD_CTRL: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d = '0;
          case (phase_q)
            PH_LEAD: begin
              sclk_d  = 1'b0;
              dio_d   = tx_bit;
              phase_d = PH_LOW;
            end
            PH_LOW: begin
              sclk_d  = 1'b1;
              phase_d = PH_HIGH;
            end
            default: begin
              if (bit_q == last_bit) begin
                // The last high phase doubles as the stb hold time.
                stb_d   = 1'b1;
                dio_d   = 1'b1;
                bit_d   = '0;
                phase_d = PH_LEAD;
                case (state_q)
                  CMD_MODE:  state_d = GAP1;
                  ADDR_DATA: state_d = GAP2;
                  default: begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                  end
                endcase
              end else begin
                bit_d   = bit_q + BIT_W'(1);
                sclk_d  = 1'b0;
                dio_d   = tx_bit;
                phase_d = PH_LOW;
              end
            end
          endcase
        end
      end

      GAP1, GAP2: begin
        if (div_q != GAP_LAST) begin
          div_d = div_q + DIV_W'(1);
        end else begin
          div_d   = '0;
          stb_d   = 1'b0;
          phase_d = PH_LEAD;
          state_d = (state_q == GAP1) ? ADDR_DATA : CMD_CTRL;
        end
      end

      // done is high and busy low here; start is ignored for this one cycle.
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_50M or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      phase_q  <= PH_LEAD;
      div_q    <= '0;
      bit_q    <= '0;
      seg_q    <= '0;
      bright_q <= '0;
      on_q     <= 1'b0;
`ifdef TM1638_LED_EN
      led_q    <= '0;
`endif
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stb_q    <= 1'b1;
      sclk_q   <= 1'b1;
      dio_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      seg_q    <= seg_d;
      bright_q <= bright_d;
      on_q     <= on_d;
`ifdef TM1638_LED_EN
      led_q    <= led_d;
`endif
      busy_q   <= busy_d;
      done_q   <= done_d;
      stb_q    <= stb_d;
      sclk_q   <= sclk_d;
      dio_q    <= dio_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign stb  = stb_q;
  assign sclk = sclk_q;
  assign dio  = dio_q;

endmodule

// File: tb/tb_tm1638_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_tm1638_frame_writer
//
// Two instances: A (NUM_DIGITS=8, CLK_DIV=2) and B (NUM_DIGITS=4, CLK_DIV=3).
// A bus monitor decodes bytes on sclk rising edges, records stb-low window
// sizes, sclk run lengths, inter-command gap lengths and done pulses. Expected
// frames come from exp_byte(), which builds the frame byte list directly from
// the command sequence rules. Optional LED checks follow TM1638_LED_EN.
// ---------------------------------------------------------------------------
module tb_tm1638_frame_writer;

`ifdef TM1638_LED_EN
  localparam bit LED_EN = 1'b1;
`else
  localparam bit LED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  // Instance A
  logic        start_a = 1'b0;
  logic [63:0] seg_a   = '0;
  logic [2:0]  bri_a   = '0;
  logic        on_a    = 1'b0;
  logic [7:0]  led_a   = '0;
  logic        busy_a, done_a, stb_a, sclk_a, dio_a;
  // Instance B
  logic        start_b = 1'b0;
  logic [31:0] seg_b   = '0;
  logic [2:0]  bri_b   = '0;
  logic        on_b    = 1'b0;
  logic [3:0]  led_b   = '0;
  logic        busy_b, done_b, stb_b, sclk_b, dio_b;

  tm1638_frame_writer #(.NUM_DIGITS(8), .CLK_DIV(2)) u_dut_a (
    .clk_50M(clk), .RST(rst), .start(start_a), .seg_data(seg_a),
    .brightness(bri_a), .display_on(on_a),
`ifdef TM1638_LED_EN
    .led_data(led_a),
`endif
    .busy(busy_a), .done(done_a), .stb(stb_a), .sclk(sclk_a), .dio(dio_a)
  );

  tm1638_frame_writer #(.NUM_DIGITS(4), .CLK_DIV(3)) u_dut_b (
    .clk_50M(clk), .RST(rst), .start(start_b), .seg_data(seg_b),
    .brightness(bri_b), .display_on(on_b),
`ifdef TM1638_LED_EN
    .led_data(led_b),
`endif
    .busy(busy_b), .done(done_b), .stb(stb_b), .sclk(sclk_b), .dio(dio_b)
  );

  logic [1:0] stb_v, sclk_v, dio_v, busy_v, done_v;
  assign stb_v  = {stb_b,  stb_a};
  assign sclk_v = {sclk_b, sclk_a};
  assign dio_v  = {dio_b,  dio_a};
  assign busy_v = {busy_b, busy_a};
  assign done_v = {done_b, done_a};

  int errors = 0;
  int checks = 0;

  // ---------------- bus monitor ----------------
  logic [7:0] cap_mem [2][1024];
  int         cap_n   [2];
  int         win_mem [2][256];
  int         win_n   [2];
  int         run_mem [2][8192];
  int         run_n   [2];
  int         gap_mem [2][256];
  int         gap_n   [2];
  int         done_n  [2];
  int         dio_bad [2];
  logic [7:0] sh      [2];
  int         bitc    [2];
  int         inwin   [2];
  int         run_len [2];
  int         hi_len  [2];
  logic [1:0] stb_p, sclk_p, dio_p, busy_p;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (stb_p[i] === 1'b0 && stb_v[i] === 1'b0 && dio_v[i] !== dio_p[i] &&
          !(sclk_p[i] === 1'b1 && sclk_v[i] === 1'b0))
        dio_bad[i]++;
      if (stb_p[i] === 1'b0 && stb_v[i] === 1'b0 && sclk_p[i] === 1'b0 && sclk_v[i] === 1'b1) begin
        sh[i] = {dio_v[i], sh[i][7:1]};
        bitc[i]++;
        if (bitc[i] == 8) begin
          cap_mem[i][cap_n[i] % 1024] = sh[i];
          cap_n[i]++;
          bitc[i] = 0;
          inwin[i]++;
        end
      end
      if (stb_v[i] === 1'b1 && stb_p[i] === 1'b0) begin
        win_mem[i][win_n[i] % 256] = inwin[i];
        win_n[i]++;
        run_mem[i][run_n[i] % 8192] = run_len[i];
        run_n[i]++;
        hi_len[i] = 1;
      end else if (stb_v[i] === 1'b0 && stb_p[i] === 1'b1) begin
        if (busy_p[i] === 1'b1) begin
          gap_mem[i][gap_n[i] % 256] = hi_len[i];
          gap_n[i]++;
        end
        bitc[i]    = 0;
        inwin[i]   = 0;
        run_len[i] = 1;
      end else if (stb_v[i] === 1'b0) begin
        if (sclk_v[i] === sclk_p[i]) run_len[i]++;
        else begin
          run_mem[i][run_n[i] % 8192] = run_len[i];
          run_n[i]++;
          run_len[i] = 1;
        end
      end else begin
        hi_len[i]++;
      end
      if (done_v[i] === 1'b1) done_n[i]++;
    end
    stb_p  = stb_v;
    sclk_p = sclk_v;
    dio_p  = dio_v;
    busy_p = busy_v;
  end

  // ---------------- reference model ----------------
  // Frame byte idx: 0x40 | 0xC0, (seg k, led byte k) per digit | control.
  function automatic logic [7:0] exp_byte(int idx, int nd, logic [63:0] seg,
                                          logic [7:0] led, logic [2:0] b, logic on);
    int j;
    if (idx == 0) return 8'h40;
    if (idx == 1) return 8'hC0;
    if (idx == 2 * nd + 2) return on ? (8'h88 | {5'b0, b}) : (8'h80 | {5'b0, b});
    j = idx - 2;
    if (j % 2 == 0) return seg[8 * (j / 2) +: 8];
    return LED_EN ? {7'b0, led[j / 2]} : 8'h00;
  endfunction

  // Pulses start on instance i and waits (bounded) for done.
  task automatic run_frame(input int i, output bit ok, output int busy_low);
    ok = 1'b0;
    busy_low = 0;
    @(negedge clk);
    if (i == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (done_v[i] === 1'b1) begin ok = 1'b1; break; end
      if (busy_v[i] !== 1'b1) busy_low++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({stb_v[i], sclk_v[i], dio_v[i], busy_v[i], done_v[i]} !== 5'b11100) begin
        errors++;
        $display("FAIL reset_idle inst%0d got stb/sclk/dio/busy/done=%b exp=11100", i,
                 {stb_v[i], sclk_v[i], dio_v[i], busy_v[i], done_v[i]});
      end
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({stb_v[i], sclk_v[i], dio_v[i], busy_v[i], done_v[i]} !== 5'b11100) begin
        errors++;
        $display("FAIL post_reset_idle inst%0d got=%b exp=11100", i,
                 {stb_v[i], sclk_v[i], dio_v[i], busy_v[i], done_v[i]});
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_frame;
    bit ok; int bl, bc, bw, bd, bg, bdio;
    seg_a = {8{8'h3F}}; bri_a = 3'd7; on_a = 1'b1; led_a = 8'h00;
    bc = cap_n[0]; bw = win_n[0]; bd = done_n[0]; bg = gap_n[0]; bdio = dio_bad[0];
    run_frame(0, ok, bl);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got=no_done exp=done"); end
    checks++;
    if (bl != 0) begin errors++; $display("FAIL basic_busy_low got=%0d exp=0", bl); end
    checks++;
    if (cap_n[0] - bc != 19) begin errors++; $display("FAIL basic_nbytes got=%0d exp=19", cap_n[0] - bc); end
    for (int k = 0; k < 19; k++) begin
      checks++;
      if (cap_mem[0][(bc + k) % 1024] !== exp_byte(k, 8, seg_a, led_a, bri_a, on_a)) begin
        errors++;
        $display("FAIL basic_byte%0d got=%02h exp=%02h", k, cap_mem[0][(bc + k) % 1024],
                 exp_byte(k, 8, seg_a, led_a, bri_a, on_a));
      end
    end
    checks++;
    if (win_n[0] - bw != 3 || win_mem[0][bw % 256] != 1 || win_mem[0][(bw + 1) % 256] != 17 ||
        win_mem[0][(bw + 2) % 256] != 1) begin
      errors++;
      $display("FAIL basic_windows got n=%0d %0d/%0d/%0d exp n=3 1/17/1", win_n[0] - bw,
               win_mem[0][bw % 256], win_mem[0][(bw + 1) % 256], win_mem[0][(bw + 2) % 256]);
    end
    checks++;
    if (done_n[0] - bd != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done_n[0] - bd); end
    checks++;
    if (gap_n[0] - bg != 2 || gap_mem[0][bg % 256] != 4 || gap_mem[0][(bg + 1) % 256] != 4) begin
      errors++;
      $display("FAIL basic_gaps got n=%0d %0d/%0d exp n=2 4/4", gap_n[0] - bg,
               gap_mem[0][bg % 256], gap_mem[0][(bg + 1) % 256]);
    end
    checks++;
    if (dio_bad[0] != bdio) begin errors++; $display("FAIL basic_dio_stable got=%0d exp=0", dio_bad[0] - bdio); end
    $display("test_basic_frame done");
  endtask

  task automatic test_random_frames;
    bit ok; int bl, bc, bd;
    for (int f = 0; f < 4; f++) begin
      seg_a = {$urandom, $urandom}; bri_a = 3'($urandom_range(0, 7));
      on_a = 1'($urandom_range(0, 1)); led_a = 8'($urandom);
      bc = cap_n[0]; bd = done_n[0];
      run_frame(0, ok, bl);
      checks++;
      if (!ok || done_n[0] - bd != 1 || cap_n[0] - bc != 19) begin
        errors++;
        $display("FAIL rand%0d_frame got ok=%0d done=%0d bytes=%0d exp 1/1/19", f, ok, done_n[0] - bd, cap_n[0] - bc);
      end
      for (int k = 0; k < 19; k++) begin
        checks++;
        if (cap_mem[0][(bc + k) % 1024] !== exp_byte(k, 8, seg_a, led_a, bri_a, on_a)) begin
          errors++;
          $display("FAIL rand%0d_byte%0d got=%02h exp=%02h", f, k, cap_mem[0][(bc + k) % 1024],
                   exp_byte(k, 8, seg_a, led_a, bri_a, on_a));
        end
      end
      $display("random frame %0d seg=%016h bri=%0d on=%0d checked", f, seg_a, bri_a, on_a);
    end
  endtask

  task automatic test_div3_frame;
    bit ok; int bl, bc, bw, br, bg, bd, bad_runs;
    seg_b = $urandom; bri_b = 3'd2; on_b = 1'b0; led_b = 4'($urandom);
    bc = cap_n[1]; bw = win_n[1]; br = run_n[1]; bg = gap_n[1]; bd = done_n[1];
    run_frame(1, ok, bl);
    checks++;
    if (!ok || bl != 0 || done_n[1] - bd != 1) begin
      errors++;
      $display("FAIL div3_frame got ok=%0d busy_low=%0d done=%0d exp 1/0/1", ok, bl, done_n[1] - bd);
    end
    checks++;
    if (win_n[1] - bw != 3 || win_mem[1][(bw + 1) % 256] != 9) begin
      errors++;
      $display("FAIL div3_window got n=%0d data=%0d exp n=3 data=9", win_n[1] - bw, win_mem[1][(bw + 1) % 256]);
    end
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (cap_mem[1][(bc + k) % 1024] !== exp_byte(k, 4, {32'h0, seg_b}, {4'h0, led_b}, bri_b, on_b)) begin
        errors++;
        $display("FAIL div3_byte%0d got=%02h exp=%02h", k, cap_mem[1][(bc + k) % 1024],
                 exp_byte(k, 4, {32'h0, seg_b}, {4'h0, led_b}, bri_b, on_b));
      end
    end
    checks++;
    if (cap_mem[1][(bc + 10) % 1024] !== 8'h82) begin
      errors++;
      $display("FAIL div3_ctrl got=%02h exp=82", cap_mem[1][(bc + 10) % 1024]);
    end
    bad_runs = 0;
    for (int r = br; r < run_n[1]; r++) if (run_mem[1][r % 8192] != 3) bad_runs++;
    checks++;
    if (bad_runs != 0 || run_n[1] - br != 179) begin
      errors++;
      $display("FAIL div3_halfperiod got bad=%0d runs=%0d exp bad=0 runs=179", bad_runs, run_n[1] - br);
    end
    checks++;
    if (gap_n[1] - bg != 2 || gap_mem[1][bg % 256] != 6 || gap_mem[1][(bg + 1) % 256] != 6) begin
      errors++;
      $display("FAIL div3_gaps got n=%0d %0d/%0d exp n=2 6/6", gap_n[1] - bg,
               gap_mem[1][bg % 256], gap_mem[1][(bg + 1) % 256]);
    end
    $display("test_div3_frame done");
  endtask

  task automatic test_ignore_start;
    logic [63:0] seg1; logic [7:0] led1; bit ok; int bc, bd;
    seg1 = {$urandom, $urandom}; led1 = 8'($urandom);
    seg_a = seg1; led_a = led1; bri_a = 3'd5; on_a = 1'b1;
    bc = cap_n[0]; bd = done_n[0];
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (60) @(negedge clk);
    seg_a = ~seg1; led_a = ~led1; bri_a = 3'd1; on_a = 1'b0;
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (done_a === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
    checks++;
    if (!ok || done_n[0] - bd != 1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL ignore_done got ok=%0d done=%0d busy=%b exp 1/1/0", ok, done_n[0] - bd, busy_a);
    end
    for (int k = 0; k < 19; k++) begin
      checks++;
      if (cap_mem[0][(bc + k) % 1024] !== exp_byte(k, 8, seg1, led1, 3'd5, 1'b1)) begin
        errors++;
        $display("FAIL ignore_byte%0d got=%02h exp=%02h", k, cap_mem[0][(bc + k) % 1024],
                 exp_byte(k, 8, seg1, led1, 3'd5, 1'b1));
      end
    end
    $display("test_ignore_start done");
  endtask

  task automatic test_reset_mid;
    bit ok; int bl, bc, bd;
    seg_a = {$urandom, $urandom}; bri_a = 3'd3; on_a = 1'b1; led_a = 8'($urandom);
    bc = cap_n[0]; bd = done_n[0];
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    ok = 1'b0;
    // Bytes 0..5 done means the 5th data byte is on the wire.
    for (int c = 0; c < 2000; c++) begin
      if (cap_n[0] - bc >= 6) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_reach got=timeout exp=byte6"); end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({stb_a, sclk_a, dio_a, busy_a, done_a} !== 5'b11100) begin
      errors++;
      $display("FAIL rstmid_async got=%b exp=11100", {stb_a, sclk_a, dio_a, busy_a, done_a});
    end
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (done_n[0] != bd || busy_a !== 1'b0 || stb_a !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_aborted got done=%0d busy=%b stb=%b exp 0/0/1", done_n[0] - bd, busy_a, stb_a);
    end
    seg_a = {$urandom, $urandom};
    bc = cap_n[0];
    run_frame(0, ok, bl);
    checks++;
    if (!ok || cap_n[0] - bc != 19) begin
      errors++;
      $display("FAIL rstmid_refr got ok=%0d bytes=%0d exp 1/19", ok, cap_n[0] - bc);
    end
    for (int k = 0; k < 19; k++) begin
      checks++;
      if (cap_mem[0][(bc + k) % 1024] !== exp_byte(k, 8, seg_a, led_a, bri_a, on_a)) begin
        errors++;
        $display("FAIL rstmid_byte%0d got=%02h exp=%02h", k, cap_mem[0][(bc + k) % 1024],
                 exp_byte(k, 8, seg_a, led_a, bri_a, on_a));
      end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back;
    bit ok; int bc;
    seg_a = {$urandom, $urandom}; bri_a = 3'd6; on_a = 1'b1; led_a = 8'($urandom);
    @(negedge clk); start_a = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done1 got ok=%0d busy=%b exp 1/0", ok, busy_a);
    end
    bc = cap_n[0];
    @(negedge clk);
    checks++;
    if ({busy_a, done_a, stb_a} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_idle_cycle got busy/done/stb=%b exp=001", {busy_a, done_a, stb_a});
    end
    @(negedge clk);
    checks++;
    if ({busy_a, stb_a} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_restart got busy/stb=%b exp=10", {busy_a, stb_a});
    end
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done_a === 1'b1) begin ok = 1'b1; break; end
    end
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (!ok || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done2 got ok=%0d busy=%b exp 1/0", ok, busy_a);
    end
    for (int k = 0; k < 19; k++) begin
      checks++;
      if (cap_mem[0][(bc + k) % 1024] !== exp_byte(k, 8, seg_a, led_a, bri_a, on_a)) begin
        errors++;
        $display("FAIL b2b_byte%0d got=%02h exp=%02h", k, cap_mem[0][(bc + k) % 1024],
                 exp_byte(k, 8, seg_a, led_a, bri_a, on_a));
      end
    end
    $display("test_back_to_back done");
  endtask

`ifdef TM1638_LED_EN
  task automatic test_led;
    bit ok; int bl, bc;
    logic [7:0] pat;
    pat = 8'b1010_0101;
    seg_a = {$urandom, $urandom}; bri_a = 3'd4; on_a = 1'b1; led_a = pat;
    bc = cap_n[0];
    run_frame(0, ok, bl);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap_mem[0][(bc + 3 + 2 * k) % 1024] !== {7'b0, pat[k]}) begin
        errors++;
        $display("FAIL led_odd%0d got=%02h exp=%02h", k, cap_mem[0][(bc + 3 + 2 * k) % 1024], {7'b0, pat[k]});
      end
    end
    $display("test_led done");
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_random_frames();
    test_div3_frame();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef TM1638_LED_EN
    test_led();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tm1638_frame_writer.md
TM1638_FRAME_WRITER -- requirements
Module: tm1638_frame_writer

Interface
REQ-001 Parameter NUM_DIGITS, default 8: digit count written per frame, legal 1..8.
REQ-002 Parameter CLK_DIV, default 25: clk_50M cycles per sclk half-period, legal 2..255; default gives 1 MHz sclk.
REQ-003 Port clk_50M  input  1: sole clock, all state on rising edge.
REQ-004 Port RST  input  1: asynchronous, active-high reset.
REQ-005 Port start  input  1: frame request, sampled each clk_50M edge.
REQ-006 Port seg_data  input  8*NUM_DIGITS: segment byte per digit, digit k = bits [8k+7:8k].
REQ-007 Port brightness  input  3: TM1638 pulse-width code 0..7.
REQ-008 Port display_on  input  1: 1 = display enabled in control command.
REQ-009 Port busy  output  1: high from start acceptance until done.
REQ-010 Port done  output  1: one-cycle pulse at frame completion.
REQ-011 Ports stb, sclk, dio  output  1 each: TM1638 strobe, serial clock, serial data (write-only).

Function
REQ-012 start with busy low SHALL be accepted: seg_data, brightness, display_on (and led_data, see REQ-027) are latched that cycle and busy rises the next cycle.
REQ-013 start while busy high SHALL be ignored; latched frame data SHALL NOT change mid-frame.
REQ-014 FSM states: IDLE, CMD_MODE, GAP1, ADDR_DATA, GAP2, CMD_CTRL, FINISH; IDLE->CMD_MODE on accept, each command state -> next gap/state after its last bit, FINISH->IDLE after one cycle.
REQ-015 CMD_MODE SHALL send byte 0x40 (write, auto-increment).
REQ-016 ADDR_DATA SHALL send 0xC0 followed by 2*NUM_DIGITS bytes under one stb-low window: even byte index 2k = digit k segments, odd byte 2k+1 = LED byte.
REQ-017 CMD_CTRL SHALL send 0x88|brightness when display_on=1, else 0x80|brightness.
REQ-018 Every byte SHALL be shifted LSB first; per bit sclk low CLK_DIV cycles then high CLK_DIV cycles; dio updates on the sclk falling edge and is stable across the rising edge.
REQ-019 stb SHALL fall CLK_DIV cycles before the first sclk falling edge of a command and rise CLK_DIV cycles after its last sclk rising edge.
REQ-020 GAP1/GAP2 SHALL hold stb high for 2*CLK_DIV cycles between commands.
REQ-021 Idle levels: stb=1, sclk=1, dio=1, busy=0, done=0.
REQ-022 done SHALL pulse in FINISH, same cycle busy falls; a start in that cycle is ignored, a start on the next cycle is accepted (back-to-back frames).
REQ-023 Bit/byte counters SHALL be sized for 8*(2*NUM_DIGITS+1) bits; no wrap beyond last byte.

Reset
REQ-024 RST high SHALL immediately force stb=1, sclk=1, dio=1, busy=0, done=0, FSM=IDLE, counters and latches zero, regardless of clock.
REQ-025 RST asserted mid-frame SHALL abort the frame without done; after release the block waits for a new start.

Configuration
REQ-026 Macro TM1638_LED_EN selects LED support.
REQ-027 With TM1638_LED_EN defined: input port led_data, width NUM_DIGITS, exists; odd byte 2k+1 = {7'b0, led_data[k]}.
REQ-028 Without TM1638_LED_EN: no led_data port; all odd bytes are 0x00; all other behaviour identical.

Verification
REQ-029 NUM_DIGITS=8, CLK_DIV=2, seg_data all 0x3F, brightness=7, display_on=1, start pulse -> bytes captured on sclk rise: 0x40 | 0xC0,(0x3F,0x00)x8 | 0x8F; done once; busy high throughout.
REQ-030 NUM_DIGITS=4, CLK_DIV=3, display_on=0, brightness=2 -> ADDR_DATA window carries 9 bytes; control byte 0x82; every sclk half-period exactly 3 cycles.
REQ-031 start re-pulsed while busy with different seg_data -> frame carries original data, single done.
REQ-032 RST pulsed during 5th data byte -> stb/sclk/dio high within same cycle, no done; subsequent start yields complete correct frame.
REQ-033 TM1638_LED_EN defined, led_data=8'b1010_0101 -> odd bytes 0x01,0x00,0x01,0x00,0x00,0x01,0x00,0x01.
REQ-034 start held high continuously -> consecutive frames separated by exactly one idle cycle after done.
